// File: rtl/ped_request_scheduler.sv
// ped_request_scheduler: debounces NS/EW pedestrian buttons, latches requests and issues them
// round-robin to the traffic controller over valid/ack, with timeout abort and a minimum crossing gap.
module ped_request_scheduler #(
    parameter int DEBOUNCE = 4,
    parameter int GAP      = 20,
    parameter int TIMEOUT  = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic ped_NS,
    input  logic ped_EW,
    input  logic ped_req_ack,
    input  logic serve_done,
    output logic ped_req_valid,
    output logic ped_req_dir,
    output logic ped_NS_pend,
    output logic ped_EW_pend,
    output logic ped_wait,
    output logic timeout_err
);
    localparam int DW   = $clog2(DEBOUNCE + 1);
    localparam int CMAX = (GAP > TIMEOUT) ? GAP : TIMEOUT;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_SERVE, S_GAP} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          dir, dir_n, rr, rr_n, terr, terr_n;
    logic          hs;
    logic [1:0]    raw, s1, s2, acc, pend;
    logic [DW-1:0] db [2];

    assign raw = {ped_EW, ped_NS};
    assign hs  = (state == S_REQ) && ped_req_ack;

    // index 0 is NS, 1 is EW, matching the ped_req_dir encoding
    for (genvar d = 0; d < 2; d++) begin : g_dir
        assign acc[d] = s2[d] && (db[d] == DW'(DEBOUNCE - 1));
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                s1[d]   <= 1'b0;
                s2[d]   <= 1'b0;
                db[d]   <= '0;
                pend[d] <= 1'b0;
            end else begin
                s1[d]   <= raw[d];
                s2[d]   <= s1[d];
                db[d]   <= !s2[d] ? '0 : (db[d] == DW'(DEBOUNCE)) ? db[d] : db[d] + DW'(1);
                pend[d] <= acc[d] | (pend[d] & ~(hs && dir == 1'(d)));
            end
        end
    end

    always_comb begin
        state_n = state;
        dir_n   = dir;
        rr_n    = rr;
        terr_n  = 1'b0;
        cnt_n   = (cnt == CW'(CMAX)) ? cnt : cnt + CW'(1);
        case (state)
            S_IDLE: if (|pend) begin
                state_n = S_REQ;
                dir_n   = &pend ? rr : pend[1];
                cnt_n   = '0;
            end
            S_REQ: if (ped_req_ack) begin
                state_n = S_SERVE;
                rr_n    = ~dir;
            end else if (cnt == CW'(TIMEOUT - 1)) begin
                state_n = S_GAP;
                rr_n    = ~dir;
                terr_n  = 1'b1;
                cnt_n   = '0;
            end
            S_SERVE: if (serve_done) begin
                state_n = S_GAP;
                cnt_n   = '0;
            end
            default: if (cnt == CW'(GAP - 1)) state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            dir   <= 1'b0;
            rr    <= 1'b0;
            terr  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            dir   <= dir_n;
            rr    <= rr_n;
            terr  <= terr_n;
        end
    end

    assign ped_req_valid = (state == S_REQ);
    assign ped_req_dir   = dir;
    assign ped_NS_pend   = pend[0];
    assign ped_EW_pend   = pend[1];
    assign ped_wait      = |pend || state == S_REQ || state == S_SERVE;
    assign timeout_err   = terr;
endmodule

// File: tb/tb_ped_request_scheduler.sv
// tb_ped_request_scheduler: directed stimulus, cycle-level reference model with per-cycle compare,
// plus hand-computed literal expectations at the key points of each scenario.
module tb_ped_request_scheduler;
    localparam int DEB = 4;
    localparam int GP  = 20;
    localparam int TO  = 50;

    logic clk = 1'b0;
    logic rst;
    logic ped_NS = 1'b0, ped_EW = 1'b0, ack = 1'b0, sd = 1'b0;
    logic valid, dir, pend_ns, pend_ew, wait_o, terr;

    ped_request_scheduler #(.DEBOUNCE(DEB), .GAP(GP), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .ped_NS(ped_NS), .ped_EW(ped_EW),
        .ped_req_valid(valid), .ped_req_dir(dir), .ped_req_ack(ack), .serve_done(sd),
        .ped_NS_pend(pend_ns), .ped_EW_pend(pend_ew), .ped_wait(wait_o), .timeout_err(terr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: raw samples delayed two cycles, run length of synced-high cycles,
    // and a phase with an entry timestamp (0 idle, 1 request, 2 serving, 3 gap).
    int cyc, run_n, run_e, ph, since;
    bit m1n, m2n, m1e, m2e, mpn, mpe, mrr, mdir, mterr, an, ae, mhs;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            {m1n, m2n, m1e, m2e, mpn, mpe, mrr, mdir, mterr} = '0;
            run_n = 0; run_e = 0; ph = 0; since = 0;
        end else begin
            cyc++;
            run_n = m2n ? run_n + 1 : 0;
            run_e = m2e ? run_e + 1 : 0;
            an = (run_n == DEB);
            ae = (run_e == DEB);
            m2n = m1n; m1n = ped_NS;
            m2e = m1e; m1e = ped_EW;
            mterr = 0;
            mhs = 0;
            case (ph)
                0: if (mpn || mpe) begin
                    mdir = (mpn && mpe) ? mrr : mpe;
                    ph = 1;
                    since = cyc;
                end
                1: if (ack) begin
                    mhs = 1; mrr = !mdir; ph = 2;
                end else if (cyc - since == TO) begin
                    mterr = 1; mrr = !mdir; ph = 3; since = cyc;
                end
                2: if (sd) begin
                    ph = 3; since = cyc;
                end
                default: if (cyc - since == GP) ph = 0;
            endcase
            mpn = an || (mpn && !(mhs && !mdir));
            mpe = ae || (mpe && !(mhs && mdir));
        end
    end

    always @(posedge clk) begin
        #1;
        if (rst === 1'b1)
            check("outputs{valid,dir,ns,ew,wait,terr}",
                  {2'b0, valid, dir, pend_ns, pend_ew, wait_o, terr},
                  {2'b0, ph == 1, mdir, mpn, mpe, mpn || mpe || ph == 1 || ph == 2, mterr});
    end

    initial begin
        // 1: outputs held low in reset with buttons high; NS press latency
        rst = 1'b0; ped_NS = 1'b1; ped_EW = 1'b1;
        tick(3);
        check("reset_outputs", {valid, dir, pend_ns, pend_ew, wait_o, terr}, 8'h0);
        ped_EW = 1'b0; rst = 1'b1;
        tick(5);
        check("ns_pend_early", pend_ns, 0);
        tick(1);
        check("ns_pend_rise", {pend_ns, valid}, 8'b10);
        tick(1);
        check("ns_req_issue", {valid, dir}, 8'b10);
        ack = 1'b1; tick(1); ack = 1'b0;
        check("ns_ack", {valid, pend_ns, wait_o}, 8'b001);
        ped_NS = 1'b0;
        tick(3); sd = 1'b1; tick(1); sd = 1'b0;
        tick(GP + 3);
        // 2: short glitch ignored
        ped_EW = 1'b1; tick(2); ped_EW = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("glitch_ignored", {pend_ew, wait_o}, 8'b00);
        end
        // 3: both pressed together from reset, round-robin order
        rst = 1'b0; tick(2); rst = 1'b1;
        ped_NS = 1'b1; ped_EW = 1'b1;
        tick(6);
        check("both_pend", {pend_ns, pend_ew, valid}, 8'b110);
        tick(1);
        check("both_first_ns", {valid, dir}, 8'b10);
        ack = 1'b1; tick(1); ack = 1'b0;
        check("both_after_ack", {valid, pend_ns, pend_ew}, 8'b001);
        ped_NS = 1'b0; ped_EW = 1'b0;
        tick(2); sd = 1'b1; tick(1); sd = 1'b0;
        tick(GP);
        check("gap_holds", valid, 0);
        tick(1);
        check("both_second_ew", {valid, dir}, 8'b11);
        ack = 1'b1; tick(1); ack = 1'b0;
        tick(2); sd = 1'b1; tick(1); sd = 1'b0;
        tick(GP + 3);
        // 4: timeout abort and reissue
        ped_NS = 1'b1; tick(6);
        check("to_pend", pend_ns, 1);
        ped_NS = 1'b0; tick(1);
        check("to_issue", valid, 1);
        tick(TO - 1);
        check("to_before", {valid, terr}, 8'b10);
        tick(1);
        check("to_abort", {valid, terr, pend_ns}, 8'b011);
        tick(1);
        check("to_pulse_end", terr, 0);
        tick(GP - 1);
        check("to_gap", valid, 0);
        tick(1);
        check("to_reissue", {valid, dir}, 8'b10);
        ack = 1'b1; tick(1); ack = 1'b0;
        // 5: re-press during SERVE, and accept coinciding with the ack edge
        ped_NS = 1'b1; tick(6);
        check("serve_repress", {pend_ns, valid}, 8'b10);
        ped_NS = 1'b0;
        sd = 1'b1; tick(1); sd = 1'b0;
        tick(GP + 1);
        check("repress_issue", {valid, dir}, 8'b10);
        ped_NS = 1'b1; tick(5);
        ack = 1'b1; tick(1); ack = 1'b0;
        check("set_wins", {valid, pend_ns}, 8'b01);
        ped_NS = 1'b0;
        // 6: asynchronous reset while serving
        ped_EW = 1'b1; tick(6);
        check("pre_reset", {pend_ew, wait_o, valid}, 8'b110);
        #2 rst = 1'b0; ped_EW = 1'b0;
        #1 check("async_reset", {valid, pend_ns, pend_ew, wait_o}, 8'h0);
        @(negedge clk); rst = 1'b1; sd = 1'b1;
        tick(1); sd = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("post_reset_idle", {valid, wait_o}, 8'b00);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
